t_pulse_gen: RTL and testbench
==============================

# t_pulse_gen

Programmable toggle-request generator that sits directly upstream of the T flip-flop stage and drives its `t` input. After a start request it emits single-cycle `t` pulses at a fixed period. It runs either continuously until stopped or for a programmed burst length. The downstream T flip-flop therefore toggles a known number of times at a known rate, which the T flip-flop benches and divider chains rely on.

## Interface
- `PW`, 8: width of the period field and period counter.
- `CW`, 8: width of the burst-length field and the pulse counter.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on rising `clk`.
- `start`  in  1  level; a high level sampled in IDLE launches a run.
- `stop`  in  1  level; a high level sampled in RUN aborts the run.
- `mode`  in  1  0 = continuous, 1 = burst; latched at start.
- `period`  in  PW  cycles between pulses; 0 is treated as 1; latched at start.
- `burst_len`  in  CW  pulses per burst (mode 1 only); latched at start.
- `t`  out  1  registered toggle pulse; drives the T flip-flop `t` input.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse at burst completion.
- `pulse_cnt`  out  CW  pulses emitted since the last accepted start.

## Operation
- States:
  - IDLE: start && !stop → RUN; a zero-length burst goes IDLE → DONE instead.
  - RUN: stop → IDLE (abort); last burst pulse emitted → DONE.
  - DONE: always → IDLE after one cycle.
- Start acceptance:
  - Latches `mode`, `period` and `burst_len` into shadow registers.
  - Clears `pulse_cnt`.
  - Loads the period counter.
- Input changes after start have no effect until the next start.
- Period counter:
  - Down-counts from the effective period P = max(`period`, 1).
  - A pulse fires when the counter expires; the counter then reloads with P.
- Each emitted pulse increments `pulse_cnt`.
  - Continuous mode: `pulse_cnt` wraps modulo 2^CW; the run continues.
  - Burst mode: when `pulse_cnt` reaches `burst_len`, no further pulses fire.
- `start` is ignored in RUN and DONE; there is no restart mid-run.
- `stop` is ignored in IDLE and DONE.
- When `start` and `stop` are both high in IDLE, `stop` wins and the run does not launch.
- Abort: `t` and `busy` go low and `done` is not asserted. `pulse_cnt` holds its value until the next start.
- Reset mid-run: the block returns to IDLE immediately and the pulse train is discarded.

## Timing
- Reset values: `t`=0, `busy`=0, `done`=0, `pulse_cnt`=0; state IDLE; shadow registers 0.
- Latency: start is sampled at edge E0. The first `t` is high in the cycle after E0, with `busy` high from that same cycle.
- Subsequent pulses are high in the cycles following E0+P, E0+2P, and so on. With P=1, `t` stays high on consecutive cycles.
- `t` is never high for a cycle that was not scheduled. All outputs are registered; there are no combinational paths from inputs to outputs.
- Burst of N≥1 pulses: the last pulse is in the cycle after E0+(N−1)P.
  - `done` is high for exactly the next cycle, with `busy` low.
  - A start can be accepted again in the cycle after `done`.
- Burst of N=0: `done` is high in the cycle after E0. No `t` pulse, `busy` stays low, `pulse_cnt`=0.
- Stop sampled at edge Es during RUN:
  - `t` and `busy` are low from the cycle after Es.
  - A pulse scheduled for that cycle is suppressed and not counted.
- Back-to-back operation: start held high through DONE is accepted on the first IDLE cycle. This gives at least one idle cycle between runs, during which `t` is 0.

## Structure
- Package `t_pulse_pkg` holds:
  - the state encoding (IDLE, RUN, DONE);
  - the mode constants (MODE_CONT = 0, MODE_BURST = 1);
  - the default widths.
- Sub-module `pulse_timer`:
  - a PW-bit reloadable down-counter with `load`, `en` and `expire` ports;
  - it handles the period=0→1 clamp.
- The FSM, pulse counter and shadow registers live in `t_pulse_gen`.
- The integration bench instantiates `t_pulse_gen` feeding the T flip-flop (`t` → `t`, shared `clk`/`rst`).

## Test plan
- Reset: hold `rst` for 3 cycles with `start`=1. Required: all outputs 0 throughout and no pulse.
- Burst: `mode`=1, `period`=3, `burst_len`=4, start at E0.
  - `t` high in the cycles after E0, E0+3, E0+6 and E0+9, and nowhere else.
  - `done` high for one cycle after that, `pulse_cnt`=4.
  - Downstream T flip-flop `q` returns to 0.
- Period 0 continuous: `mode`=0, `period`=0. Required: `t` high on every cycle after E0; after 10 cycles, `pulse_cnt`=10.
- Abort: `mode`=0, `period`=5. Assert `stop` on the edge where the third pulse is due. Required: that pulse is suppressed, `pulse_cnt`=2, `busy` low next cycle, `done` never high.
- Edge cases:
  - `start` and `stop` high together in IDLE → no run.
  - `burst_len`=0 → `done` only, no `t`.
  - `start` pulsed during RUN → ignored; timing of the run unchanged.
- Reset mid-burst: `mode`=1, `period`=2, `burst_len`=8, with `rst` at the 3rd pulse. Required: outputs 0 the next cycle, then a fresh start behaves exactly as from power-up.

Source files
------------

// File: rtl/t_pulse_gen_pkg.sv
// Shared constants for the toggle-request generator: state encoding, mode
// values and default field widths.
package t_pulse_pkg;

    localparam int PW_DEF = 8;
    localparam int CW_DEF = 8;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/t_pulse_gen_pulse_timer.sv
// Reloadable period down-counter. expire marks the cycle whose edge should
// launch a pulse; a period of 0 is clamped to 1 so the timer never stalls.
module pulse_timer #(
    parameter int PW = t_pulse_pkg::PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  logic [PW-1:0] period,
    output logic          expire
);

    localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic [PW-1:0] reload;

    assign reload = (period == '0) ? ONE : period;
    assign expire = en && (cnt_q == ONE);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = reload;
        end else if (en) begin
            cnt_d = expire ? reload : (cnt_q - ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/t_pulse_gen.sv
// Toggle-request generator: after an accepted start it drives single-cycle
// t pulses at a latched period, either continuously or for a fixed burst.
module t_pulse_gen
    import t_pulse_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [PW-1:0] period,
    input  logic [CW-1:0] burst_len,
    output logic          t,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pulse_cnt
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [ST_W-1:0] state_q, state_d;
    logic            t_q, t_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   pulse_cnt_q, pulse_cnt_d;

    logic            mode_q, mode_d;
    logic [PW-1:0]   period_q, period_d;
    logic [CW-1:0]   blen_q, blen_d;

    logic            start_ok;
    logic            zero_burst;
    logic            burst_full;
    logic            timer_en;
    logic            timer_expire;
    logic [PW-1:0]   timer_period;

    // stop dominates start in IDLE, so a simultaneous request never launches.
    assign start_ok   = (state_q == ST_IDLE) && start && !stop;
    assign zero_burst = (mode == MODE_BURST) && (burst_len == '0);
    assign burst_full = (mode_q != MODE_CONT) && (pulse_cnt_q == blen_q);
    assign timer_en   = (state_q == ST_RUN);

    // The timer loads straight from the inputs on the accepting edge, since
    // the shadow copy only becomes visible a cycle later.
    assign timer_period = start_ok ? period : period_q;

    pulse_timer #(
        .PW(PW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (start_ok),
        .en    (timer_en),
        .period(timer_period),
        .expire(timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        t_d         = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        pulse_cnt_d = pulse_cnt_q;
        mode_d      = mode_q;
        period_d    = period_q;
        blen_d      = blen_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    mode_d   = mode;
                    period_d = period;
                    blen_d   = burst_len;
                    if (zero_burst) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        pulse_cnt_d = '0;
                    end else begin
                        // The first pulse goes out on the accepting edge itself.
                        state_d     = ST_RUN;
                        busy_d      = 1'b1;
                        t_d         = 1'b1;
                        pulse_cnt_d = CNT_ONE;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (burst_full) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    if (timer_expire) begin
                        t_d         = 1'b1;
                        pulse_cnt_d = pulse_cnt_q + CNT_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            t_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pulse_cnt_q <= '0;
            mode_q      <= 1'b0;
            period_q    <= '0;
            blen_q      <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pulse_cnt_q <= pulse_cnt_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            blen_q      <= blen_d;
        end
    end

    assign t         = t_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_t_pulse_gen.sv
// Integration bench: t_pulse_gen driving a T flip-flop, checked with a vector
// table, directed corner sequences and random stimulus against a schedule model.
module tb_t_pulse_gen;

    logic       clk = 1'b0;
    logic       rst, start, stop, mode;
    logic [7:0] period, burst_len;
    logic       t, busy, done;
    logic [7:0] pulse_cnt;
    logic       tff_q;

    int n_checks = 0;
    int n_pass   = 0;

    t_pulse_gen #(.PW(8), .CW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .period   (period),
        .burst_len(burst_len),
        .t        (t),
        .busy     (busy),
        .done     (done),
        .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    // Downstream T flip-flop
    always_ff @(posedge clk) begin
        if (rst) tff_q <= 1'b0;
        else if (t) tff_q <= ~tff_q;
    end

    // Reference model: a run is described by the edges elapsed since the
    // accepting edge; pulses fall on multiples of P, burst ends at (N-1)P+1.
    bit m_run = 0, m_done = 0, m_mode = 0;
    int m_k = 0, m_p = 1, m_n = 0;
    bit exp_t = 0, exp_busy = 0, exp_done = 0;
    int exp_cnt = 0;

    task automatic model_step();
        if (rst) begin
            m_run = 0; m_done = 0;
            exp_t = 0; exp_busy = 0; exp_done = 0; exp_cnt = 0;
        end else if (m_done) begin
            m_done = 0; exp_done = 0;
        end else if (!m_run) begin
            exp_t = 0; exp_busy = 0; exp_done = 0;
            if (start && !stop) begin
                m_mode = mode;
                m_p    = (period == 0) ? 1 : int'(period);
                m_n    = int'(burst_len);
                m_k    = 0;
                if (mode && burst_len == 0) begin
                    m_done = 1; exp_done = 1; exp_cnt = 0;
                end else begin
                    m_run = 1; exp_t = 1; exp_busy = 1; exp_cnt = 1;
                end
            end
        end else begin
            m_k++;
            if (stop) begin
                m_run = 0; exp_t = 0; exp_busy = 0;
            end else if (m_mode && m_k == (m_n - 1) * m_p + 1) begin
                m_run = 0; m_done = 1;
                exp_t = 0; exp_busy = 0; exp_done = 1;
            end else begin
                exp_t = ((m_k % m_p) == 0);
                if (exp_t) exp_cnt = (exp_cnt + 1) % 256;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] outs();
        return {21'd0, t, busy, done, pulse_cnt};
    endfunction

    // One clock: model follows the edge, DUT compared on the falling edge.
    task automatic tick();
        logic [7:0] ec;
        @(posedge clk);
        model_step();
        @(negedge clk);
        ec = exp_cnt[7:0];
        chk("model", outs(), {21'd0, exp_t, exp_busy, exp_done, ec});
    endtask

    typedef struct packed {
        logic       rst, start, stop, mode;
        logic [7:0] period, blen;
        logic       et, ebusy, edone;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl [22];

    initial begin
        int t_seen, done_seen, done_k;

        rst = 1; start = 1; stop = 0; mode = 0; period = 0; burst_len = 0;

        // rst start stop mode period blen | t busy done cnt
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 8'd4, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'd9, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'd9, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'd9, 1'b1, 1'b1, 1'b0, 8'd2};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd7, 8'd9, 1'b0, 1'b1, 1'b0, 8'd2};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'd9, 1'b0, 1'b1, 1'b0, 8'd2};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'd9, 1'b1, 1'b1, 1'b0, 8'd3};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'd9, 1'b0, 1'b1, 1'b0, 8'd3};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'd9, 1'b0, 1'b1, 1'b0, 8'd3};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'd9, 1'b1, 1'b1, 1'b0, 8'd4};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'd9, 1'b0, 1'b0, 1'b1, 8'd4};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'd9, 1'b0, 1'b0, 1'b0, 8'd4};

        for (int i = 0; i < 22; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop;
            mode = tbl[i].mode; period = tbl[i].period; burst_len = tbl[i].blen;
            tick();
            chk($sformatf("vec%0d", i), outs(),
                {21'd0, tbl[i].et, tbl[i].ebusy, tbl[i].edone, tbl[i].ecnt});
            $display("vec %0d: t=%0b busy=%0b done=%0b cnt=%0d", i, t, busy, done, pulse_cnt);
        end
        chk("tff_q_after_burst4", {31'd0, tff_q}, 32'd0);

        // Period 0, continuous: a pulse every cycle.
        start = 1; mode = 0; period = 0; burst_len = 0;
        t_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            start = 0;
            if (t === 1'b1) t_seen++;
        end
        chk("p0_t_every_cycle", t_seen, 10);
        chk("p0_cnt10", {24'd0, pulse_cnt}, 32'd10);
        stop = 1; tick(); stop = 0;
        chk("p0_stop_busy", {31'd0, busy}, 32'd0);
        $display("seq period0: pulses=%0d cnt=%0d", t_seen, pulse_cnt);

        // Abort on the edge where the third pulse is due (E0+10).
        tick();
        start = 1; mode = 0; period = 5;
        t_seen = 0; done_seen = 0;
        for (int k = 0; k <= 10; k++) begin
            stop = (k == 10);
            tick();
            start = 0;
            if (t === 1'b1) t_seen++;
            if (done === 1'b1) done_seen++;
        end
        stop = 0;
        chk("abort_t", {31'd0, t}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cnt", {24'd0, pulse_cnt}, 32'd2);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        chk("abort_pulses", t_seen, 2);
        chk("abort_no_done", done_seen, 0);
        $display("seq abort: pulses=%0d cnt=%0d", t_seen, pulse_cnt);

        // Reset on the third pulse of a burst, then a fresh identical run.
        start = 1; mode = 1; period = 2; burst_len = 8;
        for (int k = 0; k <= 4; k++) begin
            rst = (k == 4);
            tick();
            start = 0;
        end
        rst = 0;
        chk("rst_mid_outs", outs(), 32'd0);
        start = 1;
        t_seen = 0; done_k = -1;
        for (int k = 0; k < 40 && done_k < 0; k++) begin
            tick();
            start = 0;
            if (k == 0) chk("fresh_first", outs(), {21'd0, 1'b1, 1'b1, 1'b0, 8'd1});
            if (t === 1'b1) t_seen++;
            if (done === 1'b1) done_k = k;
        end
        chk("fresh_pulses", t_seen, 8);
        chk("fresh_done_at", done_k, 15);
        chk("fresh_cnt", {24'd0, pulse_cnt}, 32'd8);
        $display("seq reset-mid-burst: pulses=%0d done_at=%0d", t_seen, done_k);

        // Random stimulus, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            mode  = 1'($urandom_range(0, 1));
            period = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                                 : 8'($urandom_range(0, 6));
            burst_len = 8'($urandom_range(0, 6));
            tick();
            if (i % 500 == 499)
                $display("random batch ending %0d: %0d checks so far", i, n_checks);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
